// File: rtl/wallace_final_cpa.sv
// wallace_final_cpa: two-stage final carry-propagate adder of the 32x32 Wallace multiplier (option WALLACE_CPA_HI_ZERO_EN adds out_hi_zero)
module wallace_final_cpa #(
    parameter int WIDTH = 64,
    parameter int SPLIT = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_prod,
`ifdef WALLACE_CPA_HI_ZERO_EN
    output logic             out_hi_zero,
`endif
    output logic [TAG_W-1:0] out_tag
);
    localparam int HW = WIDTH - SPLIT;
    localparam int LW = SPLIT + 1;
    logic             s1_valid, s1_c, s2_valid, adv, accept;
    logic [SPLIT-1:0] s1_lo;
    logic [HW-1:0]    s1_hs, s1_hc, hi_sum;
    logic [TAG_W-1:0] s1_tag;
    logic [LW-1:0]    lo_sum;
    logic [WIDTH-1:0] prod;
    // flush overrides both the S1->S2 advance and new accepts
    assign adv       = s1_valid & (!s2_valid | out_ready) & !flush;
    assign in_ready  = !flush & (!s1_valid | adv);
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid;
    assign lo_sum    = LW'(in_sum[SPLIT-1:0]) + LW'(in_carry[SPLIT-1:0]);
    assign hi_sum    = s1_hs + s1_hc + HW'(s1_c);
    assign prod      = {hi_sum, s1_lo};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_c     <= 1'b0;
            s1_lo    <= '0;
            s1_hs    <= '0;
            s1_hc    <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            out_prod <= '0;
            out_tag  <= '0;
        end else begin
            s1_valid <= flush ? 1'b0 : accept ? 1'b1 : adv ? 1'b0 : s1_valid;
            s2_valid <= flush ? 1'b0 : adv ? 1'b1 : out_ready ? 1'b0 : s2_valid;
            if (accept) begin
                {s1_c, s1_lo} <= lo_sum;
                s1_hs         <= in_sum[WIDTH-1:SPLIT];
                s1_hc         <= in_carry[WIDTH-1:SPLIT];
                s1_tag        <= in_tag;
            end
            if (adv) begin
                out_prod <= prod;
                out_tag  <= s1_tag;
            end
        end
    end
`ifdef WALLACE_CPA_HI_ZERO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_hi_zero <= 1'b0;
        else if (adv)
            out_hi_zero <= prod[WIDTH-1:WIDTH/2] == '0;
    end
`endif
endmodule

// File: tb/tb_wallace_final_cpa.sv
// tb_wallace_final_cpa: directed self-checking bench for wallace_final_cpa
module tb_wallace_final_cpa;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic        in_ready, out_valid;
    logic [63:0] in_sum = 0, in_carry = 0, out_prod;
    logic [5:0]  in_tag = 0, out_tag;
`ifdef WALLACE_CPA_HI_ZERO_EN
    logic        out_hi_zero;
`endif
    int total = 0, passed = 0;
    logic [63:0] a, b, c;
    always #5 clk = ~clk;
    wallace_final_cpa dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_prod(out_prod),
`ifdef WALLACE_CPA_HI_ZERO_EN
        .out_hi_zero(out_hi_zero),
`endif
        .out_tag(out_tag)
    );
    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", name, obs, exp);
    endtask
    task automatic drive(input logic v, input logic [63:0] s, input logic [63:0] cy, input logic [5:0] t);
        in_valid = v;
        in_sum   = s;
        in_carry = cy;
        in_tag   = t;
    endtask
    // one isolated pair: invisible after one edge, visible after two, gone after three
    task automatic single(input string name, input logic [63:0] s, input logic [63:0] cy,
                          input logic [5:0] t, input logic [63:0] exp);
        drive(1, s, cy, t);
        @(negedge clk);
        in_valid = 0;
        chk({name, "_lat1_valid"}, out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_prod"}, out_prod, exp);
        chk({name, "_tag"}, out_tag, t);
        @(negedge clk);
        chk({name, "_drain"}, out_valid, 0);
    endtask
    initial begin
        #7;
        chk("rst_valid", out_valid, 0);
        chk("rst_prod", out_prod, 0);
        chk("rst_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        single("split", 64'h0000_0000_FFFF_FFFF, 64'h1, 6'd5, 64'h0000_0001_0000_0000);
`ifdef WALLACE_CPA_HI_ZERO_EN
        chk("split_hi_zero", out_hi_zero, 0);
`endif
        single("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 6'd9, 64'h0);
`ifdef WALLACE_CPA_HI_ZERO_EN
        chk("wrap_hi_zero", out_hi_zero, 1);
`endif
        single("x3", 64'h1_FFFF_FFFE, 64'hFFFF_FFFF, 6'd3, 64'h2_FFFF_FFFD);
        // back-to-back stream: pair k appears two edges after it is driven
        for (int k = 0; k < 11; k++) begin
            if (k >= 2 && k < 10) begin
                a = 64'(k - 2) * 64'h0123_4567_89AB_CDEF;
                chk($sformatf("tput_valid%0d", k - 2), out_valid, 1);
                chk($sformatf("tput_prod%0d", k - 2), out_prod, a + 64'hFEDC_BA98_7654_3210);
                chk($sformatf("tput_tag%0d", k - 2), out_tag, 64'(k - 2));
            end
            if (k == 10) chk("tput_drain", out_valid, 0);
            if (k < 8) begin
                chk($sformatf("tput_in_ready%0d", k), in_ready, 1);
                drive(1, 64'(k) * 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 6'(k));
            end else in_valid = 0;
            @(negedge clk);
        end
        // backpressure
        a = 64'h0000_0010_0000_0001; b = 64'hAAAA_AAAA_5555_5555; c = 64'h8000_0000_8000_0000;
        out_ready = 0;
        drive(1, a, 64'h0, 6'd10);
        @(negedge clk);
        chk("bp_in_ready1", in_ready, 1);
        drive(1, b, 64'h1, 6'd11);
        @(negedge clk);
        drive(1, c, c, 6'd12);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hold_valid%0d", k), out_valid, 1);
            chk($sformatf("bp_hold_prod%0d", k), out_prod, a);
            chk($sformatf("bp_hold_tag%0d", k), out_tag, 10);
            chk($sformatf("bp_in_ready%0d", k), in_ready, 0);
            @(negedge clk);
        end
        chk("bp_last_prod", out_prod, a);
        out_ready = 1;
        #1 chk("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_prod", out_prod, 64'hAAAA_AAAA_5555_5556);
        chk("bp_b_tag", out_tag, 11);
        @(negedge clk);
        chk("bp_c_valid", out_valid, 1);
        chk("bp_c_prod", out_prod, 64'h0000_0001_0000_0000);
        chk("bp_c_tag", out_tag, 12);
        @(negedge clk);
        chk("bp_drain", out_valid, 0);
        // flush with S1 and S2 occupied
        drive(1, 64'h11, 64'h22, 6'd20);
        @(negedge clk);
        drive(1, 64'h33, 64'h44, 6'd21);
        @(negedge clk);
        chk("fl_pre_valid", out_valid, 1);
        flush = 1;
        drive(1, 64'h55, 64'h66, 6'd22);
        #1 chk("fl_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 0;
        in_valid = 0;
        chk("fl_valid0", out_valid, 0);
        @(negedge clk);
        chk("fl_valid1", out_valid, 0);
        single("fl_after", 64'h0000_0002_FFFF_FFFF, 64'h0000_0003_0000_0002, 6'd23, 64'h0000_0006_0000_0001);
        // asynchronous reset with both stages full
        drive(1, 64'h77, 64'h1, 6'd30);
        @(negedge clk);
        drive(1, 64'h99, 64'h1, 6'd31);
        @(negedge clk);
        in_valid = 0;
        chk("ar_pre_valid", out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_prod", out_prod, 0);
        chk("ar_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("ar_no_ghost", out_valid, 0);
        single("ar_after", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4320, 6'd33, 64'h2222_2222_2222_2210);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
